// File: rtl/voltage_sample_scheduler.sv
// Periodic ADC burst sampler: every TICK_CYCLES it fetches 2^AVG_LOG2 samples over a req/valid
// handshake, publishes the truncated average with a one-cycle calc_flag and flags timeouts/overruns.
// Latency tick->calc_flag is 2N+1 cycles with a zero-wait ADC; adc_req is held until adc_valid or timeout.
// Optional build macro VSCHED_CLAMP_EN limits the published code to 2000.
module voltage_sample_scheduler #(
    parameter int TICK_CYCLES = 6000000,
    parameter int AVG_LOG2    = 3,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        adc_req,
    input  logic        adc_valid,
    input  logic [11:0] adc_data,
    output logic        calc_flag,
    output logic [11:0] calc_data,
    output logic        busy,
    output logic        timeout_err,
    output logic        overrun_err
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int WW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_PUB} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_tick_cnt;
    logic [WW-1:0]   r_wait;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_acc;
    logic            r_adc_req;
    logic            r_calc_flag;
    logic [11:0]     r_calc_data;
    logic            r_busy;
    logic            r_timeout_err;
    logic            r_overrun_err;

    logic            w_tick;
    logic            w_xfer;
    logic            w_timeout;
    logic [CW-1:0]   w_cnt_inc;
    logic [11:0]     w_avg;
    logic [11:0]     w_pub;

    assign w_tick    = (r_tick_cnt == TW'(TICK_CYCLES - 1));
    assign w_xfer    = (r_state == S_REQ) && adc_valid;
    assign w_timeout = (r_state == S_REQ) && !adc_valid && (r_wait == WW'(TIMEOUT_CYC));
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_avg     = r_acc[AVG_LOG2 +: 12];

`ifdef VSCHED_CLAMP_EN
    assign w_pub = (w_avg > 12'd2000) ? 12'd2000 : w_avg;
`else
    assign w_pub = w_avg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_tick) w_next = S_REQ;
            S_REQ: begin
                if (w_xfer) begin
                    w_next = (w_cnt_inc == CW'(1 << AVG_LOG2)) ? S_PUB : S_GAP;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_GAP:   w_next = S_REQ;
            S_PUB:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_wait        <= '0;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_adc_req     <= 1'b0;
            r_calc_flag   <= 1'b0;
            r_calc_data   <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_adc_req   <= (w_next == S_REQ);
            r_busy      <= (w_next != S_IDLE);
            r_calc_flag <= (r_state == S_PUB);
            if (r_state == S_IDLE && w_tick) begin
                r_acc  <= '0;
                r_cnt  <= '0;
                r_wait <= '0;
            end
            if (w_xfer) begin
                r_acc <= r_acc + AW'(adc_data);
                r_cnt <= w_cnt_inc;
            end else if (r_state == S_REQ && !w_timeout) begin
                r_wait <= r_wait + 1'b1;
            end
            if (r_state == S_GAP) r_wait <= '0;
            if (r_state == S_PUB) r_calc_data <= w_pub;
            if (w_timeout) r_timeout_err <= 1'b1;
            // A tick is only consumed in IDLE; anywhere else it is lost.
            if (w_tick && r_state != S_IDLE) r_overrun_err <= 1'b1;
        end
    end

    assign adc_req     = r_adc_req;
    assign calc_flag   = r_calc_flag;
    assign calc_data   = r_calc_data;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;
    assign overrun_err = r_overrun_err;

endmodule

// File: doc/voltage_sample_scheduler.md
# voltage_sample_scheduler

Sequencing controller in front of the voltage calculator. It generates the periodic 0.5 s update event and fetches and averages a burst of ADC samples through a request/valid handshake. It then presents the averaged 12-bit code with a one-cycle update flag, which the calculator and seven-segment path consume. It replaces the free-running "update every 0.5 s" flag with a sampled, averaged and fault-monitored update.

## Interface

Parameters:
- `TICK_CYCLES`, default 6000000: clock cycles per update period (0.5 s at 12 MHz).
- `AVG_LOG2`, default 3: log2 of samples averaged per update (8 samples); legal range 0..4.
- `TIMEOUT_CYC`, default 1023: maximum cycles to wait for `adc_valid` after a request.

Ports:
- `clk` in 1: 12 MHz system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `adc_req` out 1: sample request to the ADC interface.
- `adc_valid` in 1: ADC sample valid; a transfer occurs when `adc_req && adc_valid`.
- `adc_data` in 12: ADC code, sampled on a transfer.
- `calc_flag` out 1: one-cycle pulse; `calc_data` is updated in the same cycle.
- `calc_data` out 12: averaged ADC code, held between updates.
- `busy` out 1: high while not in IDLE.
- `timeout_err` out 1: sticky; set on an ADC timeout and cleared only by reset.
- `overrun_err` out 1: sticky; set when a tick arrives while busy, cleared only by reset.

## Operation

- Tick counter:
  - Counts 0..`TICK_CYCLES`-1 and wraps.
  - `tick` is high for one cycle when count == `TICK_CYCLES`-1.
  - Free-running; never stalls.
- FSM states: IDLE, REQ, GAP, PUBLISH.
  - IDLE:
    - On `tick`, clear the accumulator and the sample counter, then go to REQ.
  - REQ:
    - `adc_req`=1.
    - On a transfer: accumulator += `adc_data`, and the sample counter increments.
    - If the count now equals 2^`AVG_LOG2`, go to PUBLISH; otherwise go to GAP.
    - If the wait counter reaches `TIMEOUT_CYC` with no transfer: set `timeout_err`, discard the partial sum, and go to IDLE with no flag.
  - GAP:
    - `adc_req`=0 for exactly one cycle, then go to REQ with the wait counter reset.
  - PUBLISH:
    - `calc_data` <= accumulator >> `AVG_LOG2` (truncating).
    - `calc_flag`=1 for this cycle only.
    - Next state is IDLE.
- Accumulator width is 12+`AVG_LOG2` bits; it cannot overflow (maximum 4095·16 fits in 16 bits).
- A `tick` while in REQ, GAP or PUBLISH is dropped and sets `overrun_err`. A tick in IDLE is never dropped.
- A `tick` coincident with PUBLISH→IDLE counts as overrun; the next update occurs one full period later.
- `adc_valid` outside REQ is ignored.
- Reset mid-burst:
  - FSM returns to IDLE.
  - Accumulator, counters and all outputs take their reset values.
  - The tick counter restarts from 0.

## Timing

- Reset values:
  - `adc_req`=0, `calc_flag`=0, `calc_data`=12'd0, `busy`=0, `timeout_err`=0, `overrun_err`=0.
  - Tick count is 0.
- All outputs are registered.
- `adc_req` rises in the cycle after the FSM leaves IDLE; the `tick` cycle itself has `adc_req`=0.
- A transfer cycle is followed by `adc_req`=0 for one cycle (GAP), then `adc_req` is reasserted.
- With zero-wait ADC (`adc_valid` tied high), N=2^`AVG_LOG2` samples take 2N−1 cycles of REQ/GAP. `calc_flag` pulses 2N+1 cycles after `tick`, which is 17 cycles for N=8.
- Timeout:
  - `timeout_err` sets in the cycle after the wait counter reaches `TIMEOUT_CYC`.
  - `adc_req` drops in that same cycle.
- `busy` mirrors the state register, so it is high in REQ, GAP and PUBLISH.

## Configuration

- `VSCHED_CLAMP_EN` defined:
  - In PUBLISH, if the average exceeds 2000, `calc_data` is forced to 2000 (full-scale 5.0 V display code).
  - The clamp decision uses the full average and is made in the same PUBLISH cycle, so latency is unchanged.
- Not defined: the average passes through unmodified (0..4095).

## Test plan

- `TICK_CYCLES`=100, `AVG_LOG2`=3, `adc_valid` tied high, `adc_data` stepping 100,101..107 → one `calc_flag` pulse at tick+17 with `calc_data`=103; `adc_req` high for 8 non-consecutive cycles.
- Constant `adc_data`=4000:
  - With `VSCHED_CLAMP_EN` → `calc_data`=2000.
  - Without → `calc_data`=4000.
- `adc_valid` held low, `TIMEOUT_CYC`=15 → `timeout_err` sets, `adc_req` drops, no `calc_flag`; the next tick starts a fresh burst normally.
- `TICK_CYCLES`=10 with `adc_valid` delayed 5 cycles per sample → `overrun_err` sets; bursts still complete and publish.
- `rst_n` asserted during the 4th sample, then released → all outputs are 0; the first `calc_flag` occurs 17 cycles after the first tick following reset.
- `AVG_LOG2`=0, `adc_data`=1234 → `calc_flag` at tick+3 with `calc_data`=1234.
